// File: rtl/id_ex_stage.sv
// ID/EX stage: decodes a MIPS instruction into an ALU control code, picks forwarded
// operands, and holds the result in a stallable/flushable pipeline register.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        ex_wr_en,
   input  logic [4:0]  ex_wr_addr,
   input  logic [31:0] ex_wr_data,
   input  logic        mem_wr_en,
   input  logic [4:0]  mem_wr_addr,
   input  logic [31:0] mem_wr_data,
   input  logic        stall,
   input  logic        flush,
   output logic        in_ready,
   output logic        out_valid,
   output logic [31:0] a1,
   output logic [31:0] a2,
   output logic [3:0]  alu_ctrl,
   output logic [4:0]  dest_addr,
   output logic        dest_wr_en,
   output logic        illegal
);

   // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
   // while in_ready is low the upstream holds instr/rs_data/rt_data unchanged.
   assign in_ready = ~stall;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;
   logic [31:0] sext_imm;
   logic [31:0] zext_imm;

   assign opcode   = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign funct    = instr[5:0];
   assign imm      = instr[15:0];
   assign sext_imm = {{16{imm[15]}}, imm};
   assign zext_imm = {16'h0000, imm};

   logic [31:0] rs_val;
   logic [31:0] rt_val;

   // EX/MEM result is newer than MEM/WB, so it takes precedence.
   always_comb begin
      rs_val = rs_data;
      if (rs == 5'd0)                             rs_val = 32'd0;
      else if (ex_wr_en && ex_wr_addr == rs)      rs_val = ex_wr_data;
      else if (mem_wr_en && mem_wr_addr == rs)    rs_val = mem_wr_data;

      rt_val = rt_data;
      if (rt == 5'd0)                             rt_val = 32'd0;
      else if (ex_wr_en && ex_wr_addr == rt)      rt_val = ex_wr_data;
      else if (mem_wr_en && mem_wr_addr == rt)    rt_val = mem_wr_data;
   end

   logic [3:0]  dec_alu;
   logic [31:0] dec_a1;
   logic [31:0] dec_a2;
   logic [4:0]  dec_dest;
   logic        dec_wr;
   logic        dec_ill;

   always_comb begin
      dec_alu  = 4'b0000;
      dec_a1   = rs_val;
      dec_a2   = rt_val;
      dec_dest = rd;
      dec_wr   = 1'b0;
      dec_ill  = 1'b0;
      case (opcode)
         6'h00: begin
            dec_wr = 1'b1;
            case (funct)
               6'h20, 6'h21: dec_alu = 4'b0001;
               6'h22, 6'h23: dec_alu = 4'b0010;
               6'h24:        dec_alu = 4'b0011;
               6'h25:        dec_alu = 4'b0100;
               6'h27:        dec_alu = 4'b0101;
               6'h2A:        dec_alu = 4'b0110;
               6'h26:        dec_alu = 4'b0111;
               default: begin
                  dec_wr  = 1'b0;
                  dec_ill = 1'b1;
               end
            endcase
         end
         6'h08, 6'h09, 6'h23: begin
            dec_alu = 4'b0001; dec_a2 = sext_imm; dec_dest = rt; dec_wr = 1'b1;
         end
         6'h0A: begin
            dec_alu = 4'b0110; dec_a2 = sext_imm; dec_dest = rt; dec_wr = 1'b1;
         end
         6'h0C: begin
            dec_alu = 4'b0011; dec_a2 = zext_imm; dec_dest = rt; dec_wr = 1'b1;
         end
         6'h0D: begin
            dec_alu = 4'b0100; dec_a2 = zext_imm; dec_dest = rt; dec_wr = 1'b1;
         end
         6'h0E: begin
            dec_alu = 4'b0111; dec_a2 = zext_imm; dec_dest = rt; dec_wr = 1'b1;
         end
         6'h0F: begin
            dec_alu = 4'b0100; dec_a1 = 32'd0; dec_a2 = {imm, 16'h0000};
            dec_dest = rt; dec_wr = 1'b1;
         end
         6'h2B: begin
            dec_alu = 4'b0001; dec_a2 = sext_imm; dec_dest = rt;
         end
         6'h04, 6'h05: begin
            dec_alu = 4'b0010; dec_dest = rt;
         end
         default: dec_ill = 1'b1;
      endcase
   end

   logic        out_valid_q, out_valid_d;
   logic [31:0] a1_q, a1_d;
   logic [31:0] a2_q, a2_d;
   logic [3:0]  alu_ctrl_q, alu_ctrl_d;
   logic [4:0]  dest_addr_q, dest_addr_d;
   logic        dest_wr_en_q, dest_wr_en_d;
   logic        illegal_q, illegal_d;

   always_comb begin
      out_valid_d  = out_valid_q;
      a1_d         = a1_q;
      a2_d         = a2_q;
      alu_ctrl_d   = alu_ctrl_q;
      dest_addr_d  = dest_addr_q;
      dest_wr_en_d = dest_wr_en_q;
      illegal_d    = illegal_q;
      if (rst || flush) begin
         out_valid_d  = 1'b0;
         a1_d         = 32'd0;
         a2_d         = 32'd0;
         alu_ctrl_d   = 4'b0000;
         dest_addr_d  = 5'd0;
         dest_wr_en_d = 1'b0;
         illegal_d    = 1'b0;
      end else if (!stall) begin
         out_valid_d  = in_valid;
         a1_d         = dec_a1;
         a2_d         = dec_a2;
         alu_ctrl_d   = in_valid ? dec_alu : 4'b0000;
         dest_addr_d  = dec_dest;
         // Writes to r0 are architecturally discarded, so never advertise them.
         dest_wr_en_d = in_valid && dec_wr && (dec_dest != 5'd0);
         illegal_d    = in_valid && dec_ill;
      end
   end

   always_ff @(posedge clk) begin
      out_valid_q  <= out_valid_d;
      a1_q         <= a1_d;
      a2_q         <= a2_d;
      alu_ctrl_q   <= alu_ctrl_d;
      dest_addr_q  <= dest_addr_d;
      dest_wr_en_q <= dest_wr_en_d;
      illegal_q    <= illegal_d;
   end

   assign out_valid  = out_valid_q;
   assign a1         = a1_q;
   assign a2         = a2_q;
   assign alu_ctrl   = alu_ctrl_q;
   assign dest_addr  = dest_addr_q;
   assign dest_wr_en = dest_wr_en_q;
   assign illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, immediates, forwarding, stall/flush, reset.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] instr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        ex_wr_en;
   logic [4:0]  ex_wr_addr;
   logic [31:0] ex_wr_data;
   logic        mem_wr_en;
   logic [4:0]  mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic        stall;
   logic        flush;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] a1;
   logic [31:0] a2;
   logic [3:0]  alu_ctrl;
   logic [4:0]  dest_addr;
   logic        dest_wr_en;
   logic        illegal;

   int n_cmp = 0;
   int n_bad = 0;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
      .rs_data(rs_data), .rt_data(rt_data),
      .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .stall(stall), .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
      .a1(a1), .a2(a2), .alu_ctrl(alu_ctrl), .dest_addr(dest_addr),
      .dest_wr_en(dest_wr_en), .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [5:0] f);
      return {6'h00, s, t, d, 5'h00, f};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] im);
      return {op, s, t, im};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [3:0] alu,
                          input logic [31:0] e1, input logic [31:0] e2,
                          input logic [4:0] d, input logic w, input logic ill);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
      chk({tag, ".alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, alu});
      chk({tag, ".a1"}, a1, e1);
      chk({tag, ".a2"}, a2, e2);
      chk({tag, ".dest_addr"}, {27'd0, dest_addr}, {27'd0, d});
      chk({tag, ".dest_wr_en"}, {31'd0, dest_wr_en}, {31'd0, w});
      chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, ill});
   endtask

   typedef struct { logic [5:0] f; logic [3:0] code; } fsweep_t;
   fsweep_t sweep [8] = '{'{6'h22, 4'd2}, '{6'h24, 4'd3}, '{6'h25, 4'd4}, '{6'h27, 4'd5},
                          '{6'h2A, 4'd6}, '{6'h26, 4'd7}, '{6'h21, 4'd1}, '{6'h23, 4'd2}};

   initial begin
      rst = 1'b1; in_valid = 1'b1; instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
      rs_data = 32'd10; rt_data = 32'd1;
      ex_wr_en = 1'b0; ex_wr_addr = 5'd0; ex_wr_data = 32'd0;
      mem_wr_en = 1'b0; mem_wr_addr = 5'd0; mem_wr_data = 32'd0;
      stall = 1'b0; flush = 1'b0;

      step(); step();
      chk_out("reset", 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk_out("add", 1'b1, 4'd1, 32'd10, 32'd1, 5'd3, 1'b1, 1'b0);
      chk("in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 8; i++) begin
         instr = rtype(5'd1, 5'd2, 5'd4, sweep[i].f);
         step();
         chk($sformatf("funct%02h.alu_ctrl", sweep[i].f), {28'd0, alu_ctrl}, {28'd0, sweep[i].code});
      end

      instr = itype(6'h08, 5'd1, 5'd5, 16'hFFFC); step();
      chk_out("addi", 1'b1, 4'd1, 32'd10, 32'hFFFF_FFFC, 5'd5, 1'b1, 1'b0);
      instr = itype(6'h0D, 5'd1, 5'd5, 16'hFFFC); step();
      chk_out("ori", 1'b1, 4'd4, 32'd10, 32'h0000_FFFC, 5'd5, 1'b1, 1'b0);
      instr = itype(6'h0F, 5'd1, 5'd6, 16'h1234); step();
      chk_out("lui", 1'b1, 4'd4, 32'd0, 32'h1234_0000, 5'd6, 1'b1, 1'b0);
      instr = itype(6'h23, 5'd1, 5'd7, 16'hFFF8); step();
      chk_out("lw", 1'b1, 4'd1, 32'd10, 32'hFFFF_FFF8, 5'd7, 1'b1, 1'b0);
      instr = itype(6'h0A, 5'd1, 5'd7, 16'h8000); step();
      chk_out("slti", 1'b1, 4'd6, 32'd10, 32'hFFFF_8000, 5'd7, 1'b1, 1'b0);
      instr = itype(6'h0C, 5'd1, 5'd8, 16'h8001); step();
      chk_out("andi", 1'b1, 4'd3, 32'd10, 32'h0000_8001, 5'd8, 1'b1, 1'b0);
      instr = itype(6'h0E, 5'd1, 5'd8, 16'h00F0); step();
      chk_out("xori", 1'b1, 4'd7, 32'd10, 32'h0000_00F0, 5'd8, 1'b1, 1'b0);

      // Forwarding
      instr = rtype(5'd1, 5'd2, 5'd3, 6'h20); rs_data = 32'd7;
      ex_wr_en = 1'b1; ex_wr_addr = 5'd1; ex_wr_data = 32'd99;
      mem_wr_en = 1'b1; mem_wr_addr = 5'd1; mem_wr_data = 32'd55;
      step();
      chk("fwd_ex.a1", a1, 32'd99);
      chk("fwd_ex.a2", a2, 32'd1);
      ex_wr_en = 1'b0; step();
      chk("fwd_mem.a1", a1, 32'd55);
      mem_wr_addr = 5'd2; step();
      chk("fwd_mem_rt.a1", a1, 32'd7);
      chk("fwd_mem_rt.a2", a2, 32'd55);
      instr = rtype(5'd0, 5'd2, 5'd3, 6'h20);
      ex_wr_en = 1'b1; ex_wr_addr = 5'd0; mem_wr_addr = 5'd0; step();
      chk("fwd_r0.a1", a1, 32'd0);
      ex_wr_en = 1'b0; mem_wr_en = 1'b0; rs_data = 32'd10;

      // Stall holds, then stall+flush inserts a bubble
      instr = rtype(5'd1, 5'd2, 5'd3, 6'h20); step();
      stall = 1'b1; instr = rtype(5'd1, 5'd2, 5'd9, 6'h22);
      ex_wr_en = 1'b1; ex_wr_addr = 5'd1; ex_wr_data = 32'd123;
      #1 chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out($sformatf("stall%0d", i), 1'b1, 4'd1, 32'd10, 32'd1, 5'd3, 1'b1, 1'b0);
      end
      flush = 1'b1; step();
      chk_out("stall_flush", 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      stall = 1'b0; flush = 1'b0; ex_wr_en = 1'b0;

      in_valid = 1'b0; step();
      chk("no_valid.out_valid", {31'd0, out_valid}, 32'd0);
      chk("no_valid.alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      in_valid = 1'b1;

      instr = rtype(5'd1, 5'd2, 5'd3, 6'h3F); step();
      chk("ill_funct.out_valid", {31'd0, out_valid}, 32'd1);
      chk("ill_funct.illegal", {31'd0, illegal}, 32'd1);
      chk("ill_funct.alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      chk("ill_funct.dest_wr_en", {31'd0, dest_wr_en}, 32'd0);
      instr = itype(6'h3F, 5'd1, 5'd3, 16'h0001); step();
      chk("ill_op.out_valid", {31'd0, out_valid}, 32'd1);
      chk("ill_op.illegal", {31'd0, illegal}, 32'd1);
      chk("ill_op.alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      chk("ill_op.dest_wr_en", {31'd0, dest_wr_en}, 32'd0);

      instr = itype(6'h2B, 5'd1, 5'd2, 16'h0008); step();
      chk_out("sw", 1'b1, 4'd1, 32'd10, 32'd8, 5'd2, 1'b0, 1'b0);
      instr = itype(6'h04, 5'd1, 5'd2, 16'h0010); step();
      chk_out("beq", 1'b1, 4'd2, 32'd10, 32'd1, 5'd2, 1'b0, 1'b0);
      instr = itype(6'h05, 5'd1, 5'd2, 16'h0010); step();
      chk("bne.alu_ctrl", {28'd0, alu_ctrl}, 32'd2);
      instr = rtype(5'd1, 5'd2, 5'd0, 6'h20); step();
      chk_out("rd0", 1'b1, 4'd1, 32'd10, 32'd1, 5'd0, 1'b0, 1'b0);

      // Reset mid-stream discards the held instruction
      instr = rtype(5'd1, 5'd2, 5'd3, 6'h25); step();
      chk("pre_rst.out_valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b1; step();
      chk_out("mid_rst", 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
      rst = 1'b0; step();
      chk("post_rst.alu_ctrl", {28'd0, alu_ctrl}, 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode/issue stage sitting directly upstream of the ALU in the MIPS datapath. It decodes a 32-bit MIPS instruction into the ALU's 4-bit `alu_ctrl` code and selects the two ALU operands `a1`/`a2` from register data, forwarded results or the immediate. It then registers everything into the ID/EX pipeline register, with stall and flush support. The ALU consumes `a1`, `a2` and `alu_ctrl` directly from this block's outputs.

## Interface
- No parameters; data width fixed at 32, register address width fixed at 5.
- Reset is synchronous and active-high.
- `clk` — input, 1 bit: single clock; all state updates on its rising edge.
- `rst` — input, 1 bit: synchronous, active-high reset.
- `in_valid` — input, 1 bit: `instr`, `rs_data` and `rt_data` are valid this cycle.
- `instr` — input, 32 bits: instruction word; opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0].
- `rs_data`, `rt_data` — input, 32 bits each: register-file read data for rs and rt.
- `ex_wr_en`, `ex_wr_addr[4:0]`, `ex_wr_data[31:0]` — inputs: result currently in EX/MEM.
- `mem_wr_en`, `mem_wr_addr[4:0]`, `mem_wr_data[31:0]` — inputs: result currently in MEM/WB.
- `stall` — input, 1 bit: hold the pipeline register.
- `flush` — input, 1 bit: insert a bubble.
- `in_ready` — output, 1 bit: equals `~stall`; upstream must hold its instruction while low.
- `out_valid` — output, 1 bit: registered outputs hold a valid instruction.
- `a1`, `a2` — output, 32 bits each: ALU operands.
- `alu_ctrl` — output, 4 bits: ALU operation code.
- `dest_addr` — output, 5 bits: destination register.
- `dest_wr_en` — output, 1 bit: the instruction writes `dest_addr`.
- `illegal` — output, 1 bit: unsupported instruction.

## Operation
- ALU codes:
  - 0000 nop
  - 0001 add
  - 0010 sub
  - 0011 and
  - 0100 or
  - 0101 nor
  - 0110 slt (signed compare, result 1/0)
  - 0111 xor
- R-type (opcode 0x00), `a1`=rs value, `a2`=rt value, dest=rd:
  - funct 0x20/0x21 → 0001
  - funct 0x22/0x23 → 0010
  - funct 0x24 → 0011
  - funct 0x25 → 0100
  - funct 0x27 → 0101
  - funct 0x2A → 0110
  - funct 0x26 → 0111
  - any other funct is illegal.
- I-type, `a1`=rs value, dest=rt:
  - addi 0x08 / addiu 0x09 → add, `a2` = sign-extended imm.
  - slti 0x0A → slt, sign-extended imm.
  - andi 0x0C / ori 0x0D / xori 0x0E → and/or/xor, zero-extended imm.
  - lw 0x23 → add, sign-extended imm.
  - lui 0x0F → or, `a1`=0, `a2`={imm,16'h0}.
- No register write:
  - sw 0x2B → add, sign-extended imm, `dest_wr_en`=0.
  - beq 0x04 / bne 0x05 → sub, `a2`=rt value, `dest_wr_en`=0.
- Illegal encoding: `alu_ctrl`=0000, `dest_wr_en`=0, `illegal`=1, `out_valid`=1 (the trap is raised downstream).
- `dest_wr_en` is forced 0 when the destination is register 0.
- Forwarding, applied independently to the rs value and the rt value:
  - EX/MEM wins if `ex_wr_en` and `ex_wr_addr`==src and src≠0.
  - Otherwise MEM/WB under the same rule.
  - Otherwise register-file data.
  - src=0 always yields 0.
- Register update priority per cycle: `rst` > `flush` > `stall` > load.
  - Load: if `in_valid`, latch the decoded values with `out_valid`=1; else `out_valid`=0 and `alu_ctrl`=0000.
  - Flush: `out_valid`, `dest_wr_en`, `illegal` = 0 and `alu_ctrl`=0000; `a1`/`a2`/`dest_addr` are don't-care but cleared to 0.
  - Stall: every output holds its value; forwarded data is not re-sampled while stalled.

## Timing
- Latency 1 cycle: the instruction presented at edge N appears on the outputs after edge N.
- Decode and forwarding muxes are combinational from the inputs into the register; no output is combinational from the inputs except `in_ready`.
- Reset values: all registered outputs are 0 (`out_valid`=0, `alu_ctrl`=0000, `a1`=`a2`=0, `dest_addr`=0, `dest_wr_en`=0, `illegal`=0).
- Reset asserted mid-stream discards the held instruction on the next edge.
- Flush and stall together: flush wins and the bubble is inserted.
- The `stall` edge and the upstream hold of the instruction are the upstream's responsibility; this block never drops an instruction while `in_ready`=0.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid`=1 → all outputs 0; first valid output appears one cycle after `rst` is released.
- add r3,r1,r2 with rs_data=10 and rt_data=1, no forwarding → `alu_ctrl`=0001, `a1`=10, `a2`=1, `dest_addr`=3, `dest_wr_en`=1. Sweep sub/and/or/nor/slt/xor funct codes and check codes 0010–0111.
- Immediates:
  - addi r5,r1,-4 → `a2`=32'hFFFF_FFFC.
  - ori → `a2`=32'h0000_FFFC.
  - lui imm=0x1234 → `a1`=0, `a2`=32'h1234_0000, `alu_ctrl`=0100.
- Forwarding, rs=r1 with rs_data=7:
  - `ex_wr_en`=1, `ex_wr_addr`=1, data 99 and `mem_wr_addr`=1, data 55 → `a1`=99.
  - EX disabled → `a1`=55.
  - Same test with rs=r0 → `a1`=0.
- Stall/flush: load add then assert `stall` for 3 cycles with new instructions presented → outputs hold; `stall`+`flush` together → `out_valid`=0, `alu_ctrl`=0000.
- Illegal instructions: funct 0x3F or opcode 0x3F → `illegal`=1, `alu_ctrl`=0000, `dest_wr_en`=1 never; sw/beq/rd=0 → `dest_wr_en`=0.
